// File: rtl/elevator_display_encoder.sv
// elevator_display_encoder
// Latches floor/direction from the elevator controller and time-multiplexes
// them onto a four-digit display as 4-bit decoder codes plus active-low
// anode selects. Digit 0 shows the floor and blinks while the doors are
// open. Digit 1 shows the direction. Digits 2 and 3 stay dark.
module elevator_display_encoder #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] floor_in,
   input  logic [1:0] dir_in,
   input  logic       update,
   input  logic       door_open,
   output logic [3:0] bin,
   output logic [3:0] an,
   output logic       err
);

   localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;
   localparam logic [1:0] DIR_ILL  = 2'b11;

   localparam logic [3:0] CODE_UP      = 4'd4;
   localparam logic [3:0] CODE_DOWN    = 4'd8;
   localparam logic [3:0] CODE_NEUTRAL = 4'd12;

   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   localparam logic [1:0] FLOOR_RST = 2'd1;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } scan_t;

   // Floor codes go to the decoder unchanged in the low two bits.
   function automatic logic [3:0] floor_code(input logic [1:0] fl);
      return {2'b00, fl};
   endfunction

   // Direction codes are one-hot-ish so the decoder can draw arrows.
   // The illegal encoding can never be latched, so it falls to neutral.
   function automatic logic [3:0] dir_code(input logic [1:0] dr);
      logic [3:0] code;
      case (dr)
         DIR_UP:   code = CODE_UP;
         DIR_DOWN: code = CODE_DOWN;
         default:  code = CODE_NEUTRAL;
      endcase
      return code;
   endfunction

   // Latched controller state
   logic [1:0] floor_q, floor_d;
   logic [1:0] dir_q,   dir_d;
   logic       err_q,   err_d;

   // Refresh prescaler and blink timer
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             scan_adv;
   logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic             blink_on_q, blink_on_d;

   // Scan FSM and registered display outputs
   scan_t      scan_q;
   logic [3:0] bin_q;
   logic [3:0] an_q;

   // Next-state for the latched floor/direction and the sticky error flag
   always_comb begin
      floor_d = floor_q;
      dir_d   = dir_q;
      err_d   = err_q;
      if (update) begin
         // A zero floor is rejected and the last good floor is kept.
         if (floor_in != 2'd0) begin
            floor_d = floor_in;
         end else begin
            err_d = 1'b1;
         end
         // An illegal direction parks the display on neutral.
         if (dir_in != DIR_ILL) begin
            dir_d = dir_in;
         end else begin
            dir_d = DIR_IDLE;
            err_d = 1'b1;
         end
      end
   end

   // Next-state for the refresh prescaler and the blink timer
   always_comb begin
      scan_adv = (pre_q == PRE_LAST);
      if (scan_adv) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + PRE_W'(1);
      end

      // Holding the timer at zero while the doors are closed guarantees
      // that every door opening starts with a full visible half-period.
      if (!door_open) begin
         blk_cnt_d  = '0;
         blink_on_d = 1'b1;
      end else if (blk_cnt_q == BLK_LAST) begin
         blk_cnt_d  = '0;
         blink_on_d = ~blink_on_q;
      end else begin
         blk_cnt_d  = blk_cnt_q + BLK_W'(1);
         blink_on_d = blink_on_q;
      end
   end

   // Latch floor, direction and error on the update strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         floor_q <= FLOOR_RST;
         dir_q   <= DIR_IDLE;
         err_q   <= 1'b0;
      end else begin
         floor_q <= floor_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   // Advance the refresh prescaler and the blink timer
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q      <= '0;
         blk_cnt_q  <= '0;
         blink_on_q <= 1'b1;
      end else begin
         pre_q      <= pre_d;
         blk_cnt_q  <= blk_cnt_d;
         blink_on_q <= blink_on_d;
      end
   end

   // Scan FSM: step through the digits and register the code/anode pair.
   // Outputs are built from the current state and latched values, so they
   // trail the scan state by one cycle and every digit lasts REFRESH_DIV.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_q <= DIG0;
         bin_q  <= floor_code(FLOOR_RST);
         an_q   <= AN_DIG0;
      end else begin
         case (scan_q)
            DIG0: begin
               // The floor code stays on bin during the dark half so the
               // decoder input never glitches; only the anode blinks.
               bin_q <= floor_code(floor_q);
               an_q  <= blink_on_q ? AN_DIG0 : AN_OFF;
               if (scan_adv) scan_q <= DIG1;
            end
            DIG1: begin
               bin_q <= dir_code(dir_q);
               an_q  <= AN_DIG1;
               if (scan_adv) scan_q <= DIG2;
            end
            DIG2: begin
               bin_q <= CODE_NEUTRAL;
               an_q  <= AN_OFF;
               if (scan_adv) scan_q <= DIG3;
            end
            default: begin
               bin_q <= CODE_NEUTRAL;
               an_q  <= AN_OFF;
               if (scan_adv) scan_q <= DIG0;
            end
         endcase
      end
   end

   assign bin = bin_q;
   assign an  = an_q;
   assign err = err_q;

endmodule

// File: tb/tb_elevator_display_encoder.sv
// Testbench for elevator_display_encoder with a cycle-level reference model
// feeding a scoreboard queue of expected bin/an/err values.
module tb_elevator_display_encoder;

   localparam int R = 4;
   localparam int B = 8;

   logic       clk;
   logic       reset;
   logic [1:0] floor_in;
   logic [1:0] dir_in;
   logic       update;
   logic       door_open;
   logic [3:0] bin;
   logic [3:0] an;
   logic       err;

   int n_chk  = 0;
   int n_fail = 0;
   string phase = "reset";

   elevator_display_encoder #(
      .REFRESH_DIV  (R),
      .BLINK_CYCLES (B)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .floor_in  (floor_in),
      .dir_in    (dir_in),
      .update    (update),
      .door_open (door_open),
      .bin       (bin),
      .an        (an),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state: time since reset and consecutive door-open edges
   int         m_cyc;
   int         m_door;
   logic [1:0] m_floor;
   logic [1:0] m_dir;
   logic       m_err;
   bit         m_valid = 0;
   logic [8:0] sb_q[$];

   // Reference model: compute what the DUT must show after this edge
   always @(posedge clk) begin
      logic [3:0] e_bin;
      logic [3:0] e_an;
      int         dig;
      bit         lit;
      if (reset) begin
         m_floor = 2'd1;
         m_dir   = 2'd0;
         m_err   = 1'b0;
         m_cyc   = 0;
         m_door  = 0;
         m_valid = 1;
         sb_q.push_back({4'd1, 4'b1110, 1'b0});
      end else if (m_valid) begin
         dig = (m_cyc / R) % 4;
         lit = ((m_door / B) % 2) == 0;
         if (dig == 0) begin
            e_bin = {2'b00, m_floor};
            e_an  = lit ? 4'b1110 : 4'b1111;
         end else if (dig == 1) begin
            e_bin = (m_dir == 2'd1) ? 4'd4 : (m_dir == 2'd2) ? 4'd8 : 4'd12;
            e_an  = 4'b1101;
         end else begin
            e_bin = 4'd12;
            e_an  = 4'b1111;
         end
         if (update) begin
            if (floor_in != 2'd0) m_floor = floor_in;
            else                  m_err   = 1'b1;
            if (dir_in != 2'd3) m_dir = dir_in;
            else begin
               m_dir = 2'd0;
               m_err = 1'b1;
            end
         end
         m_door = door_open ? m_door + 1 : 0;
         m_cyc++;
         sb_q.push_back({e_bin, e_an, m_err});
      end
   end

   // Scoreboard: pop and compare away from the active edge
   always @(negedge clk) begin
      logic [8:0] e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({phase, ".bin"}, 32'(bin), 32'(e[8:5]));
         chk({phase, ".an"},  32'(an),  32'(e[4:1]));
         chk({phase, ".err"}, 32'(err), 32'(e[0]));
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_update(input logic [1:0] fl, input logic [1:0] dr);
      floor_in = fl;
      dir_in   = dr;
      update   = 1'b1;
      run(1);
      update   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int guard;
      reset     = 1'b1;
      floor_in  = 2'd0;
      dir_in    = 2'd0;
      update    = 1'b0;
      door_open = 1'b0;
      run(2);
      chk("rst.bin", 32'(bin), 32'd1);
      chk("rst.an",  32'(an),  32'b1110);
      chk("rst.err", 32'(err), 32'd0);

      // Free-running idle frames
      phase = "idle";
      reset = 1'b0;
      run(32);

      // Legal update at the start of a digit-0 window
      phase = "upd_legal";
      do_update(2'd3, 2'd1);
      run(1);
      chk("upd_legal.bin2cyc", 32'(bin), 32'd3);
      run(20);

      // Illegal floor keeps the old floor and sets the sticky error
      phase = "bad_floor";
      do_update(2'd2, 2'd0);
      run(4);
      do_update(2'd0, 2'd2);
      run(1);
      chk("bad_floor.err", 32'(err), 32'd1);
      run(20);

      // Illegal direction parks on neutral
      phase = "bad_dir";
      do_update(2'd1, 2'd3);
      run(20);

      // Legal update after an error leaves the error set
      phase = "err_sticky";
      do_update(2'd3, 2'd1);
      run(16);
      chk("err_sticky.err", 32'(err), 32'd1);

      // Door open: blink, then drop the door during a dark half
      phase = "blink";
      door_open = 1'b1;
      run(32);
      phase = "door_close";
      door_open = 1'b0;
      run(20);
      phase = "door_drop_off";
      door_open = 1'b1;
      run(12);
      door_open = 1'b0;
      run(20);

      // Held update strobe re-samples every cycle
      phase = "upd_held";
      floor_in = 2'd2;
      dir_in   = 2'd2;
      update   = 1'b1;
      run(3);
      floor_in = 2'd1;
      run(2);
      update   = 1'b0;
      run(12);

      // Reset mid-DIG1 with the door open and the error set
      phase = "rst_mid";
      door_open = 1'b1;
      guard = 0;
      while (!(((m_cyc / R) % 4) == 1 && (m_cyc % R) == 1) && guard < 40) begin
         run(1);
         guard++;
      end
      chk("rst_mid.align", 32'(guard < 40), 32'd1);
      reset = 1'b1;
      floor_in = 2'd3;
      dir_in   = 2'd2;
      update   = 1'b1;
      run(1);
      chk("rst_mid.bin", 32'(bin), 32'd1);
      chk("rst_mid.an",  32'(an),  32'b1110);
      chk("rst_mid.err", 32'(err), 32'd0);
      reset  = 1'b0;
      update = 1'b0;
      door_open = 1'b0;
      run(16);

      // Randomised traffic
      phase = "random";
      for (int i = 0; i < 120; i++) begin
         floor_in = 2'($urandom_range(0, 3));
         dir_in   = 2'($urandom_range(0, 3));
         update   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 15) == 0) door_open = ~door_open;
         run(1);
      end
      update = 1'b0;
      run(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
